// File: rtl/instr_mem_pkg.sv
// Shared types and address-split helpers for the banked instruction memory.
// Used by instr_mem_banked and instr_mem_linebuf.
package instr_mem_pkg;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_BANK,
      SEL_ROM,
      SEL_ERR,
      SEL_LBUF
   } resp_sel_e;

   // il=1: bank from word LSBs; il=0: bank from RAM word MSBs
   function automatic logic [31:0] split_bank(
      input logic [31:0] word,
      input int unsigned nb_lg,
      input int unsigned bw,
      input bit          il
   );
      if (il) return word & ((32'd1 << nb_lg) - 32'd1);
      return word >> bw;
   endfunction

   function automatic logic [31:0] split_addr(
      input logic [31:0] word,
      input int unsigned nb_lg,
      input int unsigned bw,
      input bit          il
   );
      if (il) return word >> nb_lg;
      return word & ((32'd1 << bw) - 32'd1);
   endfunction

endpackage

// File: rtl/instr_mem_linebuf.sv
// One-entry read word buffer; fills one cycle after a macro read is issued.
// Only instantiated when INSTR_MEM_LINEBUF_EN is defined.
module instr_mem_linebuf
   import instr_mem_pkg::*;
#(
   parameter int TW = 14,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_rd,
   input  logic [TW-1:0]   i_tag,
   input  logic [DW-1:0]   i_fill_data,
   input  logic            i_wr,
   input  logic [DW/8-1:0] i_be,
   input  logic [DW-1:0]   i_wdata,
   output logic            o_hit,
   output logic [DW-1:0]   o_data
);

   logic          r_pend;
   logic [TW-1:0] r_ptag;
   logic          r_valid;
   logic [TW-1:0] r_tag;
   logic [DW-1:0] r_data;

   logic          w_nvalid;
   logic [TW-1:0] w_ntag;
   logic [DW-1:0] w_ndata;

   // a pending fill owns the entry from the next edge on
   always_comb begin
      w_nvalid = r_pend | r_valid;
      w_ntag   = r_pend ? r_ptag : r_tag;
      w_ndata  = r_pend ? i_fill_data : r_data;
      if (i_wr && w_nvalid && (w_ntag == i_tag)) begin
         for (int b = 0; b < DW / 8; b++) begin
            if (i_be[b]) w_ndata[b*8 +: 8] = i_wdata[b*8 +: 8];
         end
      end
   end

   assign o_hit  = r_pend ? (r_ptag == i_tag)
                          : (r_valid && (r_tag == i_tag));
   assign o_data = r_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend  <= 1'b0;
         r_ptag  <= '0;
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else begin
         r_pend  <= i_rd;
         r_ptag  <= i_tag;
         r_valid <= w_nvalid;
         r_tag   <= w_ntag;
         r_data  <= w_ndata;
      end
   end

endmodule

// File: rtl/instr_mem_banked.sv
// Instruction memory front-end: one req/gnt/rvalid port onto banked SRAM + boot ROM.
// Optional one-word read buffer enabled by defining INSTR_MEM_LINEBUF_EN.
module instr_mem_banked
   import instr_mem_pkg::*;
#(
   parameter  int RAM_SIZE        = 32768,
   parameter  int NUM_BANKS       = 4,
   parameter  int BANK_INTERLEAVE = 1,
   parameter  int ROM_SIZE        = 4096,
   parameter  int DATA_WIDTH      = 32,
   parameter  int ADDR_WIDTH      = $clog2(RAM_SIZE) + 1,
   localparam int NBE             = DATA_WIDTH / 8,
   localparam int BW              = $clog2(RAM_SIZE / NUM_BANKS / NBE),
   localparam int RW              = $clog2(ROM_SIZE / NBE)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_i,
   input  logic [ADDR_WIDTH-1:0]         addr_i,
   input  logic                          we_i,
   input  logic [NBE-1:0]                be_i,
   input  logic [DATA_WIDTH-1:0]         wdata_i,
   output logic                          gnt_o,
   output logic                          rvalid_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          err_o,
   output logic [NUM_BANKS-1:0]          bank_en_o,
   output logic [BW-1:0]                 bank_addr_o,
   output logic                          bank_we_o,
   output logic [NBE-1:0]                bank_be_o,
   output logic [DATA_WIDTH-1:0]         bank_wdata_o,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata_i,
   output logic                          rom_en_o,
   output logic [RW-1:0]                 rom_addr_o,
   input  logic [DATA_WIDTH-1:0]         rom_rdata_i
);

   localparam int OFF = $clog2(NBE);
   localparam int NBL = $clog2(NUM_BANKS);
   localparam int BSW = (NBL > 0) ? NBL : 1;
   localparam int TW  = ADDR_WIDTH - OFF;

   logic                  w_req;
   logic                  w_rom;
   logic                  w_hit;
   logic                  w_rdhit;
   logic [31:0]           w_word;
   logic [31:0]           w_bank32;
   logic [31:0]           w_baddr32;
   logic [BSW-1:0]        w_bank;
   logic [NUM_BANKS-1:0]  w_onehot;
   resp_sel_e             w_nsel;
   resp_sel_e             w_sel;
   logic [DATA_WIDTH-1:0] w_mac;
   logic [DATA_WIDTH-1:0] w_lbuf;
   logic                  w_unused;

   logic                  r_valid;
   resp_sel_e             r_sel;
   logic [BSW-1:0]        r_bank;

   assign w_req  = req_i & rst_n;
   assign w_rom  = addr_i[ADDR_WIDTH-1];
   assign w_word = 32'(addr_i[ADDR_WIDTH-2:OFF]);

   assign w_bank32  = split_bank(w_word, NBL, BW, BANK_INTERLEAVE != 0);
   assign w_baddr32 = split_addr(w_word, NBL, BW, BANK_INTERLEAVE != 0);
   assign w_bank    = w_bank32[BSW-1:0];
   assign w_unused  = ^{w_bank32, w_baddr32, addr_i};

   always_comb begin
      w_onehot         = '0;
      w_onehot[w_bank] = 1'b1;
   end

`ifdef INSTR_MEM_LINEBUF_EN
   instr_mem_linebuf #(
      .TW (TW),
      .DW (DATA_WIDTH)
   ) u_linebuf (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rd        (w_req & ~we_i & ~w_hit),
      .i_tag       (addr_i[ADDR_WIDTH-1:OFF]),
      .i_fill_data (w_mac),
      .i_wr        (w_req & we_i & ~w_rom),
      .i_be        (be_i),
      .i_wdata     (wdata_i),
      .o_hit       (w_hit),
      .o_data      (w_lbuf)
   );
`else
   assign w_hit  = 1'b0;
   assign w_lbuf = '0;
`endif

   assign w_rdhit = w_req & ~we_i & w_hit;

   assign gnt_o        = w_req;
   assign bank_en_o    = (w_req && !w_rom && !w_rdhit) ? w_onehot : '0;
   assign bank_addr_o  = w_baddr32[BW-1:0];
   assign bank_we_o    = w_req & we_i & ~w_rom;
   assign bank_be_o    = be_i;
   assign bank_wdata_o = wdata_i;
   assign rom_en_o     = w_req & w_rom & ~we_i & ~w_rdhit;
   assign rom_addr_o   = addr_i[OFF +: RW];

   always_comb begin
      w_nsel = SEL_NONE;
      priority case (1'b1)
         !w_req:        w_nsel = SEL_NONE;
         we_i && w_rom: w_nsel = SEL_ERR;
         we_i:          w_nsel = SEL_NONE;
         w_hit:         w_nsel = SEL_LBUF;
         w_rom:         w_nsel = SEL_ROM;
         default:       w_nsel = SEL_BANK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_sel   <= SEL_NONE;
         r_bank  <= '0;
      end else begin
         r_valid <= w_req;
         r_sel   <= w_nsel;
         r_bank  <= w_bank;
      end
   end

   // a response in flight when reset asserts is suppressed immediately
   assign w_sel    = rst_n ? r_sel : SEL_NONE;
   assign rvalid_o = r_valid & rst_n;
   assign err_o    = rvalid_o & (w_sel == SEL_ERR);
   assign w_mac    = (r_sel == SEL_ROM) ? rom_rdata_i
                   : bank_rdata_i[r_bank*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      rdata_o = '0;
      case (w_sel)
         SEL_BANK: rdata_o = w_mac;
         SEL_ROM:  rdata_o = w_mac;
         SEL_LBUF: rdata_o = w_lbuf;
         default:  rdata_o = '0;
      endcase
   end

endmodule

// File: tb/tb_instr_mem_banked.sv
// Directed bench for instr_mem_banked with behavioural SRAM bank and ROM models.
// Linebuffer steps follow INSTR_MEM_LINEBUF_EN.
module tb_instr_mem_banked;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_i;
   logic [15:0]  addr_i;
   logic         we_i;
   logic [3:0]   be_i;
   logic [31:0]  wdata_i;
   logic         gnt_o;
   logic         rvalid_o;
   logic [31:0]  rdata_o;
   logic         err_o;
   logic [3:0]   bank_en_o;
   logic [10:0]  bank_addr_o;
   logic         bank_we_o;
   logic [3:0]   bank_be_o;
   logic [31:0]  bank_wdata_o;
   logic [127:0] bank_rdata_i;
   logic         rom_en_o;
   logic [9:0]   rom_addr_o;
   logic [31:0]  rom_rdata_i;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] mem [4][2048];
   logic [31:0] rom [1024];

   always #5 clk = ~clk;

   instr_mem_banked dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_i),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .wdata_i      (wdata_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .err_o        (err_o),
      .bank_en_o    (bank_en_o),
      .bank_addr_o  (bank_addr_o),
      .bank_we_o    (bank_we_o),
      .bank_be_o    (bank_be_o),
      .bank_wdata_o (bank_wdata_o),
      .bank_rdata_i (bank_rdata_i),
      .rom_en_o     (rom_en_o),
      .rom_addr_o   (rom_addr_o),
      .rom_rdata_i  (rom_rdata_i)
   );

   // 1-cycle-latency SRAM/ROM macros
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (bank_en_o[k]) begin
            if (bank_we_o) begin
               for (int b = 0; b < 4; b++)
                  if (bank_be_o[b])
                     mem[k][bank_addr_o][b*8 +: 8] <= bank_wdata_o[b*8 +: 8];
            end else begin
               bank_rdata_i[k*32 +: 32] <= mem[k][bank_addr_o];
            end
         end
      end
      if (rom_en_o) rom_rdata_i <= rom[rom_addr_o];
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic req, input logic we,
                       input logic [15:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
      @(negedge clk);
      rst_n   = rst;
      req_i   = req;
      we_i    = we;
      addr_i  = a;
      be_i    = be;
      wdata_i = wd;
      #1;
   endtask

   task automatic rd(input logic [15:0] a);
      step(1'b1, 1'b1, 1'b0, a, 4'hF, 32'h0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [3:0] be,
                     input logic [31:0] wd);
      step(1'b1, 1'b1, 1'b1, a, be, wd);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
   endtask

   task automatic resp(input string tag, input logic [31:0] d,
                       input logic e);
      chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd1);
      chk({tag, "_err"}, 64'(err_o), 64'(e));
      chk({tag, "_rdata"}, 64'(rdata_o), 64'(d));
   endtask

   initial begin
      for (int k = 0; k < 4; k++)
         for (int a = 0; a < 2048; a++)
            mem[k][a] = 32'hA000_0000 | (32'(k) << 20) | 32'(a);
      for (int i = 0; i < 1024; i++)
         rom[i] = 32'hC0DE_0000 | 32'(i);
      bank_rdata_i = '0;
      rom_rdata_i  = '0;
      rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0;
      addr_i = '0; be_i = '0; wdata_i = '0;

      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0, 4'hF, 32'h0);
         chk("rst_outs", 64'({gnt_o, rvalid_o, err_o, rom_en_o, bank_en_o}),
             64'd0);
         chk("rst_rdata", 64'(rdata_o), 64'd0);
      end

      rd(16'h0000);
      chk("il0_gnt", 64'(gnt_o), 64'd1);
      chk("il0_en", 64'(bank_en_o), 64'b0001);
      chk("il0_addr", 64'(bank_addr_o), 64'd0);
      rd(16'h0004);
      resp("il0", 32'hA000_0000, 1'b0);
      chk("il1_en", 64'(bank_en_o), 64'b0010);
      chk("il1_addr", 64'(bank_addr_o), 64'd0);
      rd(16'h0008);
      resp("il1", 32'hA010_0000, 1'b0);
      chk("il2_en", 64'(bank_en_o), 64'b0100);
      rd(16'h000C);
      resp("il2", 32'hA020_0000, 1'b0);
      chk("il3_en", 64'(bank_en_o), 64'b1000);
      chk("il3_addr", 64'(bank_addr_o), 64'd0);
      idle();
      resp("il3", 32'hA030_0000, 1'b0);
      chk("idle_en", 64'({gnt_o, bank_en_o, rom_en_o}), 64'd0);
      idle();
      chk("idle_rvalid", 64'(rvalid_o), 64'd0);
      chk("idle_rdata", 64'(rdata_o), 64'd0);

      wr(16'h0010, 4'b0011, 32'hDEAD_BEEF);
      chk("wr_en", 64'(bank_en_o), 64'b0001);
      chk("wr_addr", 64'(bank_addr_o), 64'd1);
      chk("wr_we", 64'(bank_we_o), 64'd1);
      chk("wr_be", 64'(bank_be_o), 64'b0011);
      chk("wr_wdata", 64'(bank_wdata_o), 64'hDEAD_BEEF);
      rd(16'h0010);
      resp("wr", 32'h0, 1'b0);
      chk("rdw_en", 64'(bank_en_o), 64'b0001);
      chk("rdw_we", 64'(bank_we_o), 64'd0);
      idle();
      resp("rdw", 32'hA000_BEEF, 1'b0);

      rd(16'h8004);
      chk("rom_en", 64'(rom_en_o), 64'd1);
      chk("rom_addr", 64'(rom_addr_o), 64'd1);
      chk("rom_banks", 64'(bank_en_o), 64'd0);
      rd(16'h9008);
      resp("rom", 32'hC0DE_0001, 1'b0);
      chk("alias_addr", 64'(rom_addr_o), 64'd2);
      wr(16'h8004, 4'hF, 32'h1234_5678);
      resp("alias", 32'hC0DE_0002, 1'b0);
      chk("romwr_en", 64'({rom_en_o, bank_en_o, bank_we_o}), 64'd0);
      chk("romwr_gnt", 64'(gnt_o), 64'd1);
      rd(16'h7FFC);
      resp("romwr", 32'h0, 1'b1);
      chk("top_en", 64'(bank_en_o), 64'b1000);
      chk("top_addr", 64'(bank_addr_o), 64'h7FF);
      wr(16'h0014, 4'b0000, 32'hFFFF_FFFF);
      resp("top", 32'hA030_07FF, 1'b0);
      chk("be0_en", 64'(bank_en_o), 64'b0010);
      chk("be0_be", 64'(bank_be_o), 64'd0);
      rd(16'h0014);
      resp("be0", 32'h0, 1'b0);
      idle();
      resp("be0rd", 32'hA010_0001, 1'b0);

      rd(16'h0000);
      chk("mid_gnt", 64'(gnt_o), 64'd1);
      step(1'b0, 1'b1, 1'b0, 16'h0004, 4'hF, 32'h0);
      chk("mid_rv0", 64'(rvalid_o), 64'd0);
      chk("mid_en", 64'({gnt_o, bank_en_o, rom_en_o}), 64'd0);
      idle();
      chk("mid_rv1", 64'(rvalid_o), 64'd0);
      idle();
      chk("mid_rv2", 64'(rvalid_o), 64'd0);

      rd(16'h0020);
      chk("lb0_en", 64'(bank_en_o), 64'b0001);
      chk("lb0_addr", 64'(bank_addr_o), 64'd2);
      rd(16'h0020);
      resp("lb0", 32'hA000_0002, 1'b0);
`ifdef INSTR_MEM_LINEBUF_EN
      chk("lb1_en", 64'(bank_en_o), 64'b0000);
`else
      chk("lb1_en", 64'(bank_en_o), 64'b0001);
`endif
      wr(16'h0020, 4'b1000, 32'hAA00_0000);
      resp("lb1", 32'hA000_0002, 1'b0);
      chk("lbw_en", 64'(bank_en_o), 64'b0001);
      rd(16'h0020);
      resp("lbw", 32'h0, 1'b0);
`ifdef INSTR_MEM_LINEBUF_EN
      chk("lb2_en", 64'(bank_en_o), 64'b0000);
`else
      chk("lb2_en", 64'(bank_en_o), 64'b0001);
`endif
      idle();
      resp("lb2", 32'hAA00_0002, 1'b0);
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
